eq_coeff_bank: RTL and testbench

EQ_COEFF_BANK -- requirements
Module: eq_coeff_bank

---
 rtl/eq_pkg.sv | 43 ++++
 rtl/eq_coeff_ram.sv | 45 ++++
 rtl/eq_coeff_bank.sv | 203 ++++++++++++++++++++
 tb/tb_eq_coeff_bank.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// ---------------------------------------------------------------------------
// eq_pkg
// Definitions shared by the equalizer datapath and its coefficient bank:
//   - NR_EQ_BAND_COEFF : words per biquad band
//   - B0..A2           : word offsets inside one band
//   - cfg_state_e      : commit FSM encoding for eq_coeff_bank
//   - clog2()          : constant ceil(log2) used for address widths
//   - coeff_addr()     : flat coefficient address from (channel, band, index)
// ---------------------------------------------------------------------------
package eq_pkg;

  localparam int NR_EQ_BAND_COEFF = 5;

  // Word order inside one band: b0, b1, b2, a1, a2
  localparam int B0 = 0;
  localparam int B1 = 1;
  localparam int B2 = 2;
  localparam int A1 = 3;
  localparam int A2 = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COPY    = 2'd2
  } cfg_state_e;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Flat address: channel*bands*5 + band*5 + idx
  function automatic int coeff_addr(input int nr_bands, input int channel,
                                    input int band, input int idx);
    return (channel * nr_bands + band) * NR_EQ_BAND_COEFF + idx;
  endfunction

endpackage

// File: rtl/eq_coeff_ram.sv
// ---------------------------------------------------------------------------
// eq_coeff_ram
// Storage for both coefficient banks (DEPTH = 2 * NR_EQ_COEFF words).
// One synchronous write port and two synchronous read ports. Read data is
// registered (one-cycle latency). Contents power up as zero and are not
// affected by the design reset.
// Ports:
//   clk       : clock
//   we_i      : write enable
//   waddr_i   : write address
//   wdata_i   : write data
//   raddr_a_i : read port A address (equalizer path)
//   rdata_a_o : read port A data, registered
//   raddr_b_i : read port B address (bank copy path)
//   rdata_b_o : read port B data, registered
// ---------------------------------------------------------------------------
module eq_coeff_ram
  import eq_pkg::*;
#(
  parameter  int DEPTH = 320,
  parameter  int WIDTH = 32,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  output logic [WIDTH-1:0] rdata_a_o,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_b_o
);

  // Zero contents at configuration; no reset so the array maps onto block RAM
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  always @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_a_o <= mem[raddr_a_i];
    rdata_b_o <= mem[raddr_b_i];
  end

endmodule

// File: rtl/eq_coeff_bank.sv
// ---------------------------------------------------------------------------
// eq_coeff_bank
// Double-buffered biquad coefficient store for the equalizer. Software
// writes the shadow bank, then commits; the banks swap on an equalizer
// sample boundary and the new active bank is copied back into the new
// shadow bank so both hold the same set afterwards.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   cfg_wr         : shadow write strobe (accepted only in IDLE)
//   cfg_wr_addr    : shadow write address
//   cfg_wr_data    : shadow write data
//   cfg_commit     : request bank swap
//   cfg_busy       : commit in progress (PENDING or COPY)
//   cfg_error      : sticky, set by a rejected write, cleared by a commit
//   commit_done    : one-cycle pulse when the copy has finished
//   bank_sel       : index of the active bank
//   eq_idle        : equalizer sample boundary
//   eq_coeff_addr  : equalizer coefficient address
//   eq_coeff       : active-bank coefficient, one cycle after the address
// ---------------------------------------------------------------------------
module eq_coeff_bank
  import eq_pkg::*;
#(
  parameter  int NR_CHANNELS    = 4,
  parameter  int NR_EQ_BANDS    = 8,
  parameter  int EQ_COEFF_WIDTH = 32,
  localparam int NR_EQ_COEFF    = NR_CHANNELS * NR_EQ_BANDS * NR_EQ_BAND_COEFF,
  localparam int ADDR_W         = clog2(NR_EQ_COEFF)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_wr,
  input  logic [ADDR_W-1:0]         cfg_wr_addr,
  input  logic [EQ_COEFF_WIDTH-1:0] cfg_wr_data,
  input  logic                      cfg_commit,
  output logic                      cfg_busy,
  output logic                      cfg_error,
  output logic                      commit_done,
  output logic                      bank_sel,
  input  logic                      eq_idle,
  input  logic [ADDR_W-1:0]         eq_coeff_addr,
  output logic [EQ_COEFF_WIDTH-1:0] eq_coeff
);

  localparam int RAM_DEPTH = 2 * NR_EQ_COEFF;
  localparam int RAM_AW    = clog2(RAM_DEPTH);
  // Copy counter must reach NR_EQ_COEFF (the final write-only cycle)
  localparam int CNT_W     = clog2(NR_EQ_COEFF + 1);

  localparam logic [ADDR_W:0]    ADDR_LIMIT = (ADDR_W + 1)'(NR_EQ_COEFF);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(NR_EQ_COEFF);
  localparam logic [RAM_AW-1:0]  BANK1_BASE = RAM_AW'(NR_EQ_COEFF);

  // Bank 0 occupies words [0, N), bank 1 occupies [N, 2N)
  function automatic logic [RAM_AW-1:0] ram_index(input logic bank,
                                                  input logic [ADDR_W-1:0] addr);
    return (bank ? BANK1_BASE : '0) + RAM_AW'(addr);
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  cfg_state_e         state_q;
  logic               bank_sel_q;
  logic               cfg_busy_q;
  logic               cfg_error_q;
  logic               commit_done_q;
  logic               rd_ok_q;       // last equalizer read was in range
  logic [CNT_W-1:0]   copy_cnt_q;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic               cfg_wr_ok;
  logic               eq_addr_ok;
  logic [ADDR_W-1:0]  eq_rd_addr;
  logic [ADDR_W-1:0]  copy_rd_addr;
  logic [ADDR_W-1:0]  copy_wr_addr;

  assign cfg_wr_ok  = ({1'b0, cfg_wr_addr} < ADDR_LIMIT);
  assign eq_addr_ok = ({1'b0, eq_coeff_addr} < ADDR_LIMIT);
  // Out-of-range reads are parked on word 0; the output is masked anyway
  assign eq_rd_addr = eq_addr_ok ? eq_coeff_addr : '0;

  // COPY reads word cnt and writes word cnt-1 (data from the previous read)
  assign copy_rd_addr = (copy_cnt_q < CNT_LAST) ? ADDR_W'(copy_cnt_q) : '0;
  assign copy_wr_addr = ADDR_W'(copy_cnt_q - CNT_W'(1));

  // ---------------------------------------------------------------------
  // RAM port steering
  // ---------------------------------------------------------------------
  logic                      ram_we;
  logic [RAM_AW-1:0]         ram_waddr;
  logic [EQ_COEFF_WIDTH-1:0] ram_wdata;
  logic [RAM_AW-1:0]         ram_raddr_a;
  logic [RAM_AW-1:0]         ram_raddr_b;
  logic [EQ_COEFF_WIDTH-1:0] ram_rdata_a;
  logic [EQ_COEFF_WIDTH-1:0] ram_rdata_b;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ram_index(~bank_sel_q, cfg_wr_addr);
    ram_wdata = cfg_wr_data;
    if (state_q == ST_IDLE) begin
      // Configuration writes always target the shadow bank
      ram_we = cfg_wr && cfg_wr_ok;
    end else if (state_q == ST_COPY && copy_cnt_q != '0) begin
      // Registered read data of port B is the one-cycle copy pipeline
      ram_we    = 1'b1;
      ram_waddr = ram_index(~bank_sel_q, copy_wr_addr);
      ram_wdata = ram_rdata_b;
    end
  end

  // Port A follows bank_sel as sampled at the read edge, so a swap edge
  // still returns the old bank for that read
  assign ram_raddr_a = ram_index(bank_sel_q, eq_rd_addr);
  assign ram_raddr_b = ram_index(bank_sel_q, copy_rd_addr);

  eq_coeff_ram #(
    .DEPTH (RAM_DEPTH),
    .WIDTH (EQ_COEFF_WIDTH)
  ) u_ram (
    .clk       (clk),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wdata_i   (ram_wdata),
    .raddr_a_i (ram_raddr_a),
    .rdata_a_o (ram_rdata_a),
    .raddr_b_i (ram_raddr_b),
    .rdata_b_o (ram_rdata_b)
  );

  // ---------------------------------------------------------------------
  // Commit FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bank_sel_q    <= 1'b0;
      cfg_busy_q    <= 1'b0;
      cfg_error_q   <= 1'b0;
      commit_done_q <= 1'b0;
      rd_ok_q       <= 1'b0;
      copy_cnt_q    <= '0;
    end else begin
      commit_done_q <= 1'b0;
      rd_ok_q       <= eq_addr_ok;
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_wr && !cfg_wr_ok) begin
            cfg_error_q <= 1'b1;
          end
          // The same-cycle write has already gone to the RAM; the commit
          // then starts with a clean error flag
          if (cfg_commit) begin
            cfg_error_q <= 1'b0;
            cfg_busy_q  <= 1'b1;
            state_q     <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (cfg_wr) begin
            cfg_error_q <= 1'b1;
          end
          // Swap only on a sample boundary so a sample never mixes banks
          if (eq_idle) begin
            bank_sel_q <= ~bank_sel_q;
            copy_cnt_q <= '0;
            state_q    <= ST_COPY;
          end
        end
        ST_COPY: begin
          if (cfg_wr) begin
            cfg_error_q <= 1'b1;
          end
          if (copy_cnt_q == CNT_LAST) begin
            state_q       <= ST_IDLE;
            cfg_busy_q    <= 1'b0;
            commit_done_q <= 1'b1;
          end else begin
            copy_cnt_q <= copy_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          cfg_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign cfg_busy    = cfg_busy_q;
  assign cfg_error   = cfg_error_q;
  assign commit_done = commit_done_q;
  assign bank_sel    = bank_sel_q;
  // rd_ok_q forces zero after reset and for out-of-range addresses
  assign eq_coeff    = rd_ok_q ? ram_rdata_a : '0;

endmodule

// File: tb/tb_eq_coeff_bank.sv
// ---------------------------------------------------------------------------
// tb_eq_coeff_bank
// Directed stimulus for eq_coeff_bank with a read-data scoreboard: each
// issued coefficient read pushes its expected word, and a monitor pops and
// compares when the registered data appears. Control flags are compared
// directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_eq_coeff_bank;

  localparam int N      = 160;
  localparam int AW     = 8;
  localparam int W      = 32;
  localparam int CP_LAT = 161;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [AW-1:0] cfg_wr_addr = '0;
  logic [W-1:0]  cfg_wr_data = '0;
  logic          cfg_commit = 1'b0;
  logic          cfg_busy;
  logic          cfg_error;
  logic          commit_done;
  logic          bank_sel;
  logic          eq_idle = 1'b1;
  logic [AW-1:0] eq_coeff_addr = '0;
  logic [W-1:0]  eq_coeff;

  int n_tests = 0;
  int n_fail  = 0;

  logic         rd_vld = 1'b0;
  logic [W-1:0] exp_q[$];
  string        name_q[$];

  eq_coeff_bank #(
    .NR_CHANNELS    (4),
    .NR_EQ_BANDS    (8),
    .EQ_COEFF_WIDTH (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_wr        (cfg_wr),
    .cfg_wr_addr   (cfg_wr_addr),
    .cfg_wr_data   (cfg_wr_data),
    .cfg_commit    (cfg_commit),
    .cfg_busy      (cfg_busy),
    .cfg_error     (cfg_error),
    .commit_done   (commit_done),
    .bank_sel      (bank_sel),
    .eq_idle       (eq_idle),
    .eq_coeff_addr (eq_coeff_addr),
    .eq_coeff      (eq_coeff)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: a read issued before a posedge is compared at the next negedge
  initial begin : monitor
    logic         pend;
    logic [W-1:0] e;
    string        nm;
    forever begin
      @(posedge clk);
      pend = rd_vld;
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: read with no expectation, got 0x%08h", eq_coeff);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          $display("[TB] rd  %-18s got 0x%08h exp 0x%08h", nm, eq_coeff, e);
          check(nm, eq_coeff, e);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks are entered and left at a negedge
  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    $display("[TB] wr  addr %0d data 0x%08h", a, d);
    cfg_wr = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] e, input string nm);
    eq_coeff_addr = a;
    rd_vld = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    rd_vld = 1'b0;
  endtask

  task automatic commit_pulse();
    $display("[TB] commit (eq_idle=%0d)", eq_idle);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic wait_swap(input logic old_bank);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bank_sel !== old_bank) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL swap_timeout: bank_sel stayed %0d", old_bank);
    end
  endtask

  // Counts negedges from the swap until commit_done is seen
  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (commit_done !== 1'b1 && lat < start + 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_checks(input string tag, input int lat, input logic exp_bank);
    $display("[TB] %s done after %0d cycles", tag, lat);
    check({tag, "_latency"}, lat, CP_LAT);
    check({tag, "_bank_sel"}, bank_sel, exp_bank);
    @(negedge clk);
    check({tag, "_done_1cyc"}, commit_done, 1'b0);
    check({tag, "_busy_clr"}, cfg_busy, 1'b0);
  endtask

  task automatic full_commit(input string tag, input logic exp_bank);
    int lat;
    commit_pulse();
    wait_swap(~exp_bank);
    wait_done(0, lat);
    finish_checks(tag, lat, exp_bank);
  endtask

  initial begin : stimulus
    int lat;
    int bad;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_bank_sel", bank_sel, 1'b0);
    check("rst_busy", cfg_busy, 1'b0);
    check("rst_error", cfg_error, 1'b0);
    check("rst_done", commit_done, 1'b0);
    check("rst_coeff", eq_coeff, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Banks start zeroed
    rd(8'd0, 32'h0, "init_a0");
    rd(8'd159, 32'h0, "init_a159");

    // First commit: shadow bank 1 becomes active
    wr(8'd0, 32'h12345678);
    wr(8'd5, 32'hA5A50001);
    wr(8'd159, 32'hCAFEF00D);
    full_commit("c1", 1'b1);
    rd(8'd0, 32'h12345678, "c1_a0");
    rd(8'd5, 32'hA5A50001, "c1_a5");
    rd(8'd159, 32'hCAFEF00D, "c1_a159");
    rd(8'd1, 32'h0, "c1_a1");
    rd(8'd160, 32'h0, "oor_rd_160");
    rd(8'd255, 32'h0, "oor_rd_255");

    // Out-of-range write is dropped and flagged
    wr(8'd160, 32'hBAD0BAD0);
    check("err_oor_wr", cfg_error, 1'b1);
    rd(8'd0, 32'h12345678, "oor_wr_no_alias");
    wr(8'd1, 32'h11111111);
    check("err_sticky", cfg_error, 1'b1);

    // Commit held off by eq_idle=0 for 50 cycles
    eq_idle = 1'b0;
    commit_pulse();
    check("c2_err_clr", cfg_error, 1'b0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (bank_sel !== 1'b1 || cfg_busy !== 1'b1) bad++;
      rd((i % 2 == 0) ? 8'd0 : 8'd1, (i % 2 == 0) ? 32'h12345678 : 32'h0, "pend_old_bank");
    end
    check("pend_hold_violations", bad, 0);
    eq_idle = 1'b1;
    @(negedge clk);
    check("swap_first_idle", bank_sel, 1'b0);
    // Write rejected late in COPY, after the copy has passed its address
    repeat (99) @(negedge clk);
    wr(8'd3, 32'h33333333);
    check("err_copy_wr", cfg_error, 1'b1);
    wait_done(100, lat);
    finish_checks("c2", lat, 1'b0);
    rd(8'd1, 32'h11111111, "c2_a1");
    rd(8'd0, 32'h12345678, "c2_a0");
    rd(8'd3, 32'h0, "c2_a3");

    // Commit with a same-cycle write, then a write rejected in PENDING
    $display("[TB] commit with same-cycle wr addr 6 data 0x66666666");
    cfg_wr = 1'b1; cfg_wr_addr = 8'd6; cfg_wr_data = 32'h66666666;
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    cfg_commit = 1'b0;
    check("c3_err_clr", cfg_error, 1'b0);
    wr(8'd4, 32'h44444444);
    check("err_pend_wr", cfg_error, 1'b1);
    check("c3_swap_next_edge", bank_sel, 1'b1);
    wait_done(0, lat);
    finish_checks("c3", lat, 1'b1);
    rd(8'd6, 32'h66666666, "same_cyc_wr");
    rd(8'd4, 32'h0, "pend_wr_dropped");
    rd(8'd3, 32'h0, "copy_wr_dropped");
    rd(8'd1, 32'h11111111, "c3_a1");

    // Commit requested during COPY is ignored without error
    commit_pulse();
    wait_swap(1'b1);
    repeat (10) @(negedge clk);
    commit_pulse();
    check("copy_commit_no_err", cfg_error, 1'b0);
    check("copy_commit_busy", cfg_busy, 1'b1);
    wait_done(11, lat);
    finish_checks("c4", lat, 1'b0);
    rd(8'd6, 32'h66666666, "c4_a6");

    // Reset in the middle of COPY
    commit_pulse();
    wait_swap(1'b0);
    eq_coeff_addr = 8'd6;
    repeat (20) @(negedge clk);
    check("pre_rst_coeff", eq_coeff, 32'h66666666);
    check("pre_rst_bank", bank_sel, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] async reset mid-copy");
    check("arst_bank_sel", bank_sel, 1'b0);
    check("arst_busy", cfg_busy, 1'b0);
    check("arst_coeff", eq_coeff, 32'h0);
    check("arst_done", commit_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_coeff", eq_coeff, 32'h0);
    @(negedge clk);
    rd(8'd6, 32'h66666666, "post_rst_a6");
    full_commit("c5", 1'b1);
    rd(8'd0, 32'h12345678, "c5_a0");

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
